// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared pipeline constants: execution-controller states, the HALT opcode
// and the opcode map that MainControlUnit decodes.
package pipeline_exec_ctrl_pkg;

    // Opcode field width used by the datapath decoders
    localparam int OPCODE_W = 6;

    // Opcodes recognised by MainControlUnit
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

    // HALT is the all-ones opcode so it can never alias a real instruction
    localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 6'b111111;

    // Execution controller states; the numeric values are visible on o_state
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } exec_state_t;

    // True in the states where pipeline registers advance
    function automatic logic state_drives_pipe(input exec_state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

    // True in the states where new instructions may be fetched
    function automatic logic state_can_fetch(input exec_state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter used for the executed-cycle count. Holds at
// all-ones instead of wrapping; a synchronous clear beats an increment.
module sat_counter #(
    parameter int CNT_SZ = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic [CNT_SZ-1:0] count
);

    localparam logic [CNT_SZ-1:0] CNT_MAX = '1;
    localparam logic [CNT_SZ-1:0] CNT_ONE = {{(CNT_SZ-1){1'b0}}, 1'b1};

    // Count enabled cycles, clear on request, stick at the maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Pipeline execution controller: sequences continuous run, single step,
// pause and the HALT drain, and gates the pipeline and PC enables.
module pipeline_exec_ctrl
    import pipeline_exec_ctrl_pkg::*;
#(
    parameter int                   OPCODE_SZ    = 6,
    parameter int                   CNT_SZ       = 32,
    parameter int                   DRAIN_CYCLES = 4,
    parameter logic [OPCODE_SZ-1:0] HALT_OP      = HALT_OP_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_halt_req,
    input  logic                 i_clear,
    input  logic [OPCODE_SZ-1:0] i_instr_op_IF,
    input  logic                 i_stall_HD,
    output logic                 o_pipe_en,
    output logic                 o_pc_en,
    output logic [CNT_SZ-1:0]    o_cycle_cnt,
    output logic [2:0]           o_state,
    output logic                 o_busy,
    output logic                 o_done
);

    // Drain counter holds DRAIN_CYCLES-1 down to 0, so DRAIN lasts DRAIN_CYCLES cycles
    localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    exec_state_t        state;
    exec_state_t        next_state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_next;
    logic               halt_seen;
    logic               pipe_en;
    logic               pc_en;
    logic               done;

    // HALT only counts once it is actually leaving IF, i.e. not held by a load-use stall
    assign halt_seen = (i_instr_op_IF == HALT_OP) && !i_stall_HD;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Drain counter register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_next;
        end
    end

    // Next-state, drain-counter update and output decode; clear beats every event
    always_comb begin
        next_state = state;
        drain_next = drain_cnt;
        pipe_en    = state_drives_pipe(state);
        pc_en      = state_can_fetch(state) && !i_stall_HD && (i_instr_op_IF != HALT_OP);
        done       = (state == ST_DONE);

        if (i_clear) begin
            next_state = ST_IDLE;
            drain_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_run) begin
                        next_state = ST_RUN;
                    end else if (i_step) begin
                        next_state = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (i_halt_req) begin
                        next_state = ST_IDLE;
                    end else if (halt_seen) begin
                        next_state = ST_DRAIN;
                        drain_next = DRAIN_LOAD;
                    end
                end
                ST_STEP: begin
                    if (halt_seen) begin
                        next_state = ST_DRAIN;
                        drain_next = DRAIN_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        next_state = ST_DONE;
                    end else begin
                        drain_next = drain_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    next_state = ST_DONE;
                end
                default: begin
                    next_state = ST_IDLE;
                    drain_next = '0;
                end
            endcase
        end
    end

    assign o_pipe_en = pipe_en;
    assign o_pc_en   = pc_en;
    assign o_busy    = pipe_en;
    assign o_done    = done;
    assign o_state   = state;

    sat_counter #(
        .CNT_SZ(CNT_SZ)
    ) u_cycle_cnt (
        .clk  (i_clk),
        .rst_n(i_reset),
        .en   (pipe_en),
        .clr  (i_clear),
        .count(o_cycle_cnt)
    );

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Self-checking bench for pipeline_exec_ctrl: a default-width instance and a
// 4-bit-counter instance share all stimulus and are checked against one model.
module tb_pipeline_exec_ctrl;

    localparam logic [5:0] HALT = 6'b111111;
    localparam logic [5:0] NOP  = 6'd0;
    localparam int DRAIN_N = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_DONE = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_run = 1'b0;
    logic        i_step = 1'b0;
    logic        i_halt_req = 1'b0;
    logic        i_clear = 1'b0;
    logic [5:0]  i_instr_op_IF = NOP;
    logic        i_stall_HD = 1'b0;

    logic        pipe_en, pc_en, busy, done;
    logic [31:0] cycle_cnt;
    logic [2:0]  state;
    logic        s_pipe_en, s_pc_en, s_busy, s_done;
    logic [3:0]  s_cycle_cnt;
    logic [2:0]  s_state;

    int checks = 0;
    int errors = 0;

    int     m_mode = M_IDLE;
    longint m_count = 0;
    int     m_drained = 0;

    typedef struct {
        logic       run;
        logic       step;
        logic       halt;
        logic       clr;
        logic [5:0] op;
        logic       stall;
        int         exp_state;
        logic       exp_pipe;
        logic       exp_pc;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[15];

    pipeline_exec_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
        .i_halt_req(i_halt_req), .i_clear(i_clear), .i_instr_op_IF(i_instr_op_IF),
        .i_stall_HD(i_stall_HD), .o_pipe_en(pipe_en), .o_pc_en(pc_en),
        .o_cycle_cnt(cycle_cnt), .o_state(state), .o_busy(busy), .o_done(done)
    );

    pipeline_exec_ctrl #(.CNT_SZ(4)) dut_small (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
        .i_halt_req(i_halt_req), .i_clear(i_clear), .i_instr_op_IF(i_instr_op_IF),
        .i_stall_HD(i_stall_HD), .o_pipe_en(s_pipe_en), .o_pc_en(s_pc_en),
        .o_cycle_cnt(s_cycle_cnt), .o_state(s_state), .o_busy(s_busy), .o_done(s_done)
    );

    // Free-running clock, 10 time-unit period
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output of both instances with what the model predicts now
    task automatic compareAll();
        logic   exp_active, exp_fetch;
        longint exp_small;
        exp_active = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
        exp_fetch  = ((m_mode == M_RUN) || (m_mode == M_STEP)) && !i_stall_HD && (i_instr_op_IF != HALT);
        exp_small  = (m_count > 15) ? 15 : m_count;
        checkOutput("state", state, m_mode);
        checkOutput("pipe_en", pipe_en, exp_active);
        checkOutput("pc_en", pc_en, exp_fetch);
        checkOutput("busy", busy, exp_active);
        checkOutput("done", done, m_mode == M_DONE);
        checkOutput("cycle_cnt", cycle_cnt, m_count & 64'hFFFF_FFFF);
        checkOutput("small_state", s_state, m_mode);
        checkOutput("small_pipe_en", s_pipe_en, exp_active);
        checkOutput("small_pc_en", s_pc_en, exp_fetch);
        checkOutput("small_busy", s_busy, exp_active);
        checkOutput("small_done", s_done, m_mode == M_DONE);
        checkOutput("small_cycle_cnt", s_cycle_cnt, exp_small);
    endtask

    // Advance the reference model across one rising edge
    task automatic modelStep(input logic run, input logic step, input logic halt, input logic clr,
                             input logic [5:0] op, input logic stall);
        logic halt_cond;
        halt_cond = (op == HALT) && !stall;
        if (clr) begin
            m_mode = M_IDLE;
            m_count = 0;
            m_drained = 0;
            return;
        end
        if (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN) m_count++;
        case (m_mode)
            M_IDLE:  if (run) m_mode = M_RUN; else if (step) m_mode = M_STEP;
            M_RUN: begin
                if (halt) m_mode = M_IDLE;
                else if (halt_cond) begin m_mode = M_DRAIN; m_drained = 0; end
            end
            M_STEP: begin
                if (halt_cond) begin m_mode = M_DRAIN; m_drained = 0; end
                else m_mode = M_IDLE;
            end
            M_DRAIN: begin
                m_drained++;
                if (m_drained >= DRAIN_N) m_mode = M_DONE;
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then account for the edge
    task automatic applyStimulus(input logic run, input logic step, input logic halt, input logic clr,
                                 input logic [5:0] op, input logic stall);
        @(negedge i_clk);
        i_run = run;
        i_step = step;
        i_halt_req = halt;
        i_clear = clr;
        i_instr_op_IF = op;
        i_stall_HD = stall;
        #1;
        compareAll();
        modelStep(run, step, halt, clr, op, stall);
    endtask

    // Assert reset between edges, check the asynchronous effect, release at a falling edge
    task automatic pulseReset();
        @(negedge i_clk);
        #2;
        i_reset = 1'b0;
        i_run = 1'b0; i_step = 1'b0; i_halt_req = 1'b0; i_clear = 1'b0;
        i_instr_op_IF = NOP; i_stall_HD = 1'b0;
        #1;
        m_mode = M_IDLE;
        m_count = 0;
        m_drained = 0;
        compareAll();
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    // Main test sequence
    initial begin
        int pipe_highs;
        int drain_seen;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, NOP,  1'b0, 0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 1, 1'b1, 1'b1, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 1, 1'b1, 1'b1, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, NOP,  1'b0, 1, 1'b1, 1'b1, 2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 0, 1'b0, 1'b0, 3};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP,  1'b0, 0, 1'b0, 1'b0, 3};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 2, 1'b1, 1'b1, 3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 0, 1'b0, 1'b0, 4};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, HALT, 1'b0, 0, 1'b0, 1'b0, 4};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, HALT, 1'b0, 2, 1'b1, 1'b0, 4};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 3, 1'b1, 1'b0, 5};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 3, 1'b1, 1'b0, 6};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, NOP,  1'b0, 3, 1'b1, 1'b0, 7};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, NOP,  1'b0, 0, 1'b0, 1'b0, 0};

        repeat (3) @(negedge i_clk);
        #1;
        compareAll();
        @(negedge i_clk);
        i_reset = 1'b1;

        $display("[TB] directed vector table");
        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].run, vecs[v].step, vecs[v].halt, vecs[v].clr, vecs[v].op, vecs[v].stall);
            checkOutput($sformatf("tbl%0d_state", v), state, vecs[v].exp_state);
            checkOutput($sformatf("tbl%0d_pipe_en", v), pipe_en, vecs[v].exp_pipe);
            checkOutput($sformatf("tbl%0d_pc_en", v), pc_en, vecs[v].exp_pc);
            checkOutput($sformatf("tbl%0d_cnt", v), cycle_cnt, vecs[v].exp_cnt);
        end

        $display("[TB] run 10 cycles, stalled HALT, drain to DONE");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'($urandom_range(0, 62)), 1'b0);
            checkOutput("run_pipe_en", pipe_en, 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, HALT, 1'b1);
        checkOutput("run10_cnt", cycle_cnt, 10);
        checkOutput("stall1_pc_en", pc_en, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, HALT, 1'b1);
        checkOutput("stall2_state", state, M_RUN);
        checkOutput("stall2_cnt", cycle_cnt, 11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, HALT, 1'b0);
        checkOutput("halt_pc_en", pc_en, 0);
        checkOutput("halt_state", state, M_RUN);
        drain_seen = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, NOP, 1'b1);
            if (state == 3'd3 && pc_en == 1'b0) drain_seen++;
        end
        checkOutput("drain_cycles", drain_seen, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, NOP, 1'b0);
        checkOutput("done_flag", done, 1);
        checkOutput("done_pipe_en", pipe_en, 0);
        checkOutput("done_cnt", cycle_cnt, 17);
        checkOutput("done_small_cnt", s_cycle_cnt, 15);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
        checkOutput("done_hold_cnt", cycle_cnt, 17);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
        checkOutput("clear_from_done", state, M_IDLE);

        $display("[TB] three spaced single steps");
        pipe_highs = 0;
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, NOP, 1'b0);
            if (pipe_en) pipe_highs++;
            for (int g = 0; g < 2; g++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
                if (pipe_en) pipe_highs++;
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
        checkOutput("step_pipe_highs", pipe_highs, 3);
        checkOutput("step_cnt", cycle_cnt, 3);

        $display("[TB] saturation and reset mid-run");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
        for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0);
        checkOutput("sat_main_cnt", cycle_cnt, 20);
        checkOutput("sat_small_cnt", s_cycle_cnt, 15);
        pulseReset();
        checkOutput("rst_state", state, M_IDLE);
        checkOutput("rst_pipe_en", pipe_en, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cnt", cycle_cnt, 0);

        $display("[TB] randomized traffic against the model");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset();
            end else begin
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                              $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
                              ($urandom_range(0, 3) == 0) ? HALT : 6'($urandom_range(0, 62)),
                              $urandom_range(0, 4) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_exec_ctrl.md
PIPELINE_EXEC_CTRL -- requirements
Module: pipeline_exec_ctrl

Interface
REQ-001 SHALL have parameter OPCODE_SZ, default 6, meaning the instruction opcode field width.
REQ-002 SHALL have parameter CNT_SZ, default 32, meaning the executed-cycle counter width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, meaning the cycles needed to retire HALT from IF through WB.
REQ-004 SHALL have parameter HALT_OP, default 6'b111111, meaning the HALT opcode.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_run, input, 1 bit: a one-cycle pulse requesting continuous execution.
REQ-008 SHALL have port i_step, input, 1 bit: a one-cycle pulse requesting a single pipeline cycle.
REQ-009 SHALL have port i_halt_req, input, 1 bit: a one-cycle pulse requesting a pause.
REQ-010 SHALL have port i_clear, input, 1 bit: a one-cycle pulse that returns to IDLE and clears the counter.
REQ-011 SHALL have port i_instr_op_IF, input, OPCODE_SZ bits: the opcode of the instruction currently in IF.
REQ-012 SHALL have port i_stall_HD, input, 1 bit: the load-use stall from the hazard unit.
REQ-013 SHALL have port o_pipe_en, output, 1 bit: the global pipeline-register enable.
REQ-014 SHALL have port o_pc_en, output, 1 bit: the PC write enable.
REQ-015 SHALL have port o_cycle_cnt, output, CNT_SZ bits: the count of enabled pipeline cycles.
REQ-016 SHALL have port o_state, output, 3 bits: the current state encoding.
REQ-017 SHALL have port o_busy, output, 1 bit: high in RUN, STEP or DRAIN.
REQ-018 SHALL have port o_done, output, 1 bit: high in DONE.

Function
REQ-019 SHALL implement states IDLE=0, RUN=1, STEP=2, DRAIN=3 and DONE=4, registered on the rising edge of i_clk.
REQ-020 SHALL use this priority in every state: i_clear, then state-specific events.
REQ-021 SHALL, in IDLE, go to RUN on i_run, else go to STEP on i_step; i_run SHALL win when both are asserted.
REQ-022 SHALL, in RUN, go to IDLE on i_halt_req; else, when i_instr_op_IF==HALT_OP and i_stall_HD==0, go to DRAIN and load the drain counter with DRAIN_CYCLES-1; otherwise stay in RUN.
REQ-023 SHALL treat STEP as lasting exactly one cycle, then going to DRAIN on the HALT condition of REQ-022, else to IDLE; i_run, i_step and i_halt_req SHALL be ignored in STEP.
REQ-024 SHALL, in DRAIN, decrement the drain counter every cycle regardless of i_stall_HD and go to DONE when the counter equals 0; i_run, i_step and i_halt_req SHALL be ignored.
REQ-025 SHALL stay in DONE until i_clear; i_run and i_step SHALL be ignored in DONE.
REQ-026 SHALL drive o_pipe_en=1 exactly when the state is RUN, STEP or DRAIN, decoded from the state register only.
REQ-027 SHALL drive o_pc_en = (state==RUN or STEP) and !i_stall_HD and (i_instr_op_IF!=HALT_OP), combinationally.
REQ-028 SHALL keep o_pc_en=0 in DRAIN so the PC stays frozen on HALT.
REQ-029 SHALL give a latency of 1 cycle: an i_run or i_step sampled at edge N raises o_pipe_en after edge N.
REQ-030 SHALL increment o_cycle_cnt by 1 on each edge where o_pipe_en=1, saturating at all-ones without wrap.
REQ-031 SHALL, on i_clear in any state (including mid-DRAIN), go to IDLE on the next edge and zero o_cycle_cnt and the drain counter; i_clear SHALL override an increment in the same cycle.
REQ-032 SHALL, if DRAIN_CYCLES is 1, go from DRAIN to DONE after one cycle.

Reset
REQ-033 SHALL, while i_reset=0, asynchronously force the state to IDLE, o_cycle_cnt=0 and the drain counter to 0.
REQ-034 SHALL hold o_pipe_en=0, o_pc_en=0, o_busy=0 and o_done=0 throughout reset.
REQ-035 SHALL, when reset is asserted mid-RUN or mid-DRAIN, abandon the operation with no DONE indication.

Structure
REQ-036 SHALL place the state encodings and the HALT_OP default in the shared pipeline constants package, which MainControlUnit also uses for opcodes.
REQ-037 SHALL instantiate one sub-module, sat_counter (parameter CNT_SZ; ports en, clr, count), for o_cycle_cnt.

Verification
REQ-038 SHALL cover: reset release, then an i_run pulse with non-HALT opcodes for 10 cycles -> o_pipe_en=1 from the cycle after the pulse and o_cycle_cnt=10.
REQ-039 SHALL cover: in RUN, i_instr_op_IF=HALT_OP with i_stall_HD=0 -> o_pc_en=0 in that cycle, DRAIN for 4 cycles, then o_done=1, o_pipe_en=0, and the counter stops.
REQ-040 SHALL cover: HALT opcode present with i_stall_HD=1 for 2 cycles -> no DRAIN entry until the stall drops, o_pc_en=0 during the stall, and the counter still increments.
REQ-041 SHALL cover: three i_step pulses spaced 3 cycles apart -> o_pipe_en high for exactly 3 single cycles and o_cycle_cnt=3.
REQ-042 SHALL cover: i_run and i_step asserted together in IDLE -> RUN; i_halt_req in RUN -> IDLE with the count held; i_clear mid-DRAIN -> IDLE with the count at 0.
REQ-043 SHALL cover: with CNT_SZ=4, 20 RUN cycles -> o_cycle_cnt=15 saturated, and asserting i_reset=0 mid-RUN -> immediate IDLE with outputs at 0.
